// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader
// Input stage of a radix-2 DIT FFT. It collects N complex samples that arrive
// serially in natural order, then issues the stage-0 butterfly pairs in
// bit-reversed order, one pair per cycle, using a valid/ready handshake.
// The stage-0 twiddle is always W^0, so the twiddle outputs are constant.
module fft_bitrev_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int EXPAND     = 6,
    parameter int LOG2N      = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         out_ready,
    output logic                         en,
    output logic signed [DATA_WIDTH-1:0] in1_real,
    output logic signed [DATA_WIDTH-1:0] in1_imag,
    output logic signed [DATA_WIDTH-1:0] in2_real,
    output logic signed [DATA_WIDTH-1:0] in2_imag,
    output logic signed [EXPAND+1:0]     ro_real,
    output logic signed [EXPAND+1:0]     ro_imag,
    output logic                         frame_last
);

    localparam int N = 1 << LOG2N;

    // Counter limits expressed at counter width so comparisons stay width-clean.
    localparam logic [LOG2N-1:0] LAST_WR   = '1;
    localparam logic [LOG2N-1:0] NPAIR     = LOG2N'(N / 2);
    localparam logic [LOG2N-1:0] LAST_PAIR = LOG2N'(N / 2 - 1);
    localparam logic [LOG2N-1:0] CNT_ONE   = LOG2N'(1);

    // Twiddle W^0 = (1<<EXPAND, 0) in the Butterfly's fixed-point scale.
    localparam logic signed [EXPAND+1:0] RO_ONE = {2'b01, {EXPAND{1'b0}}};

    typedef enum logic {
        LOAD  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;

    logic [LOG2N-1:0]              r_wr_cnt;
    logic [LOG2N-1:0]              r_rd_cnt;
    logic [2*DATA_WIDTH-1:0]       r_mem [N];

    logic                          r_en;
    logic                          r_frame_last;
    logic signed [DATA_WIDTH-1:0]  r_in1_real;
    logic signed [DATA_WIDTH-1:0]  r_in1_imag;
    logic signed [DATA_WIDTH-1:0]  r_in2_real;
    logic signed [DATA_WIDTH-1:0]  r_in2_imag;

    logic                          w_accept;
    logic                          w_xfer;
    logic                          w_last_xfer;
    logic                          w_load_pair;
    logic [LOG2N-1:0]              w_addr_a;
    logic [LOG2N-1:0]              w_addr_b;
    logic [2*DATA_WIDTH-1:0]       w_rd_a;
    logic [2*DATA_WIDTH-1:0]       w_rd_b;

    // Reverse the bit order of a buffer index.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Pair k reads buffer entries bitrev(2k) and bitrev(2k+1).
    assign w_addr_a = bitrev({r_rd_cnt[LOG2N-2:0], 1'b0});
    assign w_addr_b = bitrev({r_rd_cnt[LOG2N-2:0], 1'b1});
    assign w_rd_a   = r_mem[w_addr_a];
    assign w_rd_b   = r_mem[w_addr_b];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_load_pair  = 1'b0;
        w_xfer       = r_en && out_ready;
        w_last_xfer  = r_en && out_ready && r_frame_last;
        case (r_state)
            LOAD: begin
                w_accept = in_valid;
                if (in_valid && (r_wr_cnt == LAST_WR)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_load_pair = (!r_en || out_ready) && (r_rd_cnt < NPAIR);
                if (w_last_xfer) begin
                    w_state_next = LOAD;
                end
            end
            default: w_state_next = LOAD;
        endcase
    end

    // Sample buffer write port.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; its contents are fully rewritten before
        // any entry is read, and leaving it unreset lets it map to RAM.
        if (w_accept) begin
            r_mem[r_wr_cnt] <= {in_real, in_imag};
        end
    end

    // Counters and the registered butterfly-input bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_en         <= 1'b0;
            r_frame_last <= 1'b0;
            r_in1_real   <= '0;
            r_in1_imag   <= '0;
            r_in2_real   <= '0;
            r_in2_imag   <= '0;
        end else begin
            if (w_accept) begin
                r_wr_cnt <= r_wr_cnt + CNT_ONE;
            end

            if (w_load_pair) begin
                r_in1_real   <= w_rd_a[2*DATA_WIDTH-1:DATA_WIDTH];
                r_in1_imag   <= w_rd_a[DATA_WIDTH-1:0];
                r_in2_real   <= w_rd_b[2*DATA_WIDTH-1:DATA_WIDTH];
                r_in2_imag   <= w_rd_b[DATA_WIDTH-1:0];
                r_en         <= 1'b1;
                r_frame_last <= (r_rd_cnt == LAST_PAIR);
                r_rd_cnt     <= r_rd_cnt + CNT_ONE;
            end else if (w_xfer) begin
                r_en         <= 1'b0;
                r_frame_last <= 1'b0;
            end

            // The final pair has gone downstream: rearm the read side.
            if (w_last_xfer) begin
                r_rd_cnt <= '0;
            end
        end
    end

    assign in_ready   = (r_state == LOAD);
    assign en         = r_en;
    assign frame_last = r_frame_last;
    assign in1_real   = r_in1_real;
    assign in1_imag   = r_in1_imag;
    assign in2_real   = r_in2_real;
    assign in2_imag   = r_in2_imag;
    assign ro_real    = RO_ONE;
    assign ro_imag    = '0;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// tb_fft_bitrev_loader
// Directed bench for fft_bitrev_loader with N=8. Inputs change and outputs
// are sampled 1ns after each rising edge.
module tb_fft_bitrev_loader;

    localparam int DW = 8;
    localparam int EX = 6;
    localparam int LG = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_ready;
    logic                 en;
    logic signed [DW-1:0] in1_real;
    logic signed [DW-1:0] in1_imag;
    logic signed [DW-1:0] in2_real;
    logic signed [DW-1:0] in2_imag;
    logic signed [EX+1:0] ro_real;
    logic signed [EX+1:0] ro_imag;
    logic                 frame_last;

    int tests_run;
    int tests_failed;

    // Stage-0 pair order for N=8: (0,4), (2,6), (1,5), (3,7).
    int pair_a [4] = '{0, 2, 1, 3};
    int pair_b [4] = '{4, 6, 5, 7};

    fft_bitrev_loader #(
        .DATA_WIDTH(DW),
        .EXPAND    (EX),
        .LOG2N     (LG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_ready (out_ready),
        .en        (en),
        .in1_real  (in1_real),
        .in1_imag  (in1_imag),
        .in2_real  (in2_real),
        .in2_imag  (in2_imag),
        .ro_real   (ro_real),
        .ro_imag   (ro_imag),
        .frame_last(frame_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present `count` samples base+i (imag = -(base+i)); optional idle cycle
    // after each sample. in_ready must be high on every presented cycle.
    task automatic load_frame(input int base, input bit gaps, input int count);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_real  = DW'(base + i);
            in_imag  = DW'(-(base + i));
            check($sformatf("in_ready_load_%0d", base + i), in_ready, 1);
            tick();
            if (gaps && i != count - 1) begin
                in_valid = 1'b0;
                in_real  = '0;
                in_imag  = '0;
                check($sformatf("in_ready_gap_%0d", base + i), in_ready, 1);
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_pair(input int base, input int k, input string sfx);
        check($sformatf("en_p%0d_%s", k, sfx), en, 1);
        check($sformatf("in1_real_p%0d_%s", k, sfx), in1_real, base + pair_a[k]);
        check($sformatf("in1_imag_p%0d_%s", k, sfx), in1_imag, -(base + pair_a[k]));
        check($sformatf("in2_real_p%0d_%s", k, sfx), in2_real, base + pair_b[k]);
        check($sformatf("in2_imag_p%0d_%s", k, sfx), in2_imag, -(base + pair_b[k]));
        check($sformatf("frame_last_p%0d_%s", k, sfx), frame_last, (k == 3) ? 1 : 0);
        check($sformatf("ro_real_p%0d_%s", k, sfx), ro_real, 64);
        check($sformatf("ro_imag_p%0d_%s", k, sfx), ro_imag, 0);
        check($sformatf("in_ready_issue_p%0d_%s", k, sfx), in_ready, 0);
    endtask

    // Called right after the edge that accepted sample N-1. Expects pair 0 one
    // cycle later, then one pair per cycle; pair stall_k is held for
    // stall_n extra cycles with out_ready low.
    task automatic expect_frame(input int base, input int stall_k, input int stall_n);
        check($sformatf("en_after_load_%0d", base), en, 0);
        check($sformatf("in_ready_after_load_%0d", base), in_ready, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_pair(base, k, "first");
            if (k == stall_k) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check_pair(base, k, $sformatf("stall%0d", s));
                end
                out_ready = 1'b1;
            end
        end
        tick();
        check($sformatf("en_end_%0d", base), en, 0);
        check($sformatf("frame_last_end_%0d", base), frame_last, 0);
        check($sformatf("in_ready_end_%0d", base), in_ready, 1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_real      = '0;
        in_imag      = '0;
        out_ready    = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_en", en, 0);
        check("rst_frame_last", frame_last, 0);
        check("rst_in1_real", in1_real, 0);
        check("rst_in2_imag", in2_imag, 0);
        check("rst_ro_real", ro_real, 64);
        check("rst_ro_imag", ro_imag, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Natural load, no stall.
        load_frame(0, 1'b0, 8);
        expect_frame(0, -1, 0);

        // Backpressure on pair (2,6) for 3 cycles; frame follows back-to-back.
        load_frame(0, 1'b0, 8);
        expect_frame(0, 1, 3);

        // Input gaps: in_valid toggling every cycle.
        load_frame(10, 1'b1, 8);
        expect_frame(10, -1, 0);

        // Input held valid with 99 throughout ISSUE; must not be consumed.
        load_frame(30, 1'b0, 8);
        in_valid = 1'b1;
        in_real  = DW'(99);
        in_imag  = DW'(99);
        expect_frame(30, -1, 0);

        // Back-to-back frame: must carry its own data, with no 99 inside.
        load_frame(40, 1'b0, 8);
        expect_frame(40, -1, 0);

        // Reset mid-load after 5 samples, then a fresh frame 20..27.
        load_frame(50, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_en", en, 0);
        check("midrst_frame_last", frame_last, 0);
        check("midrst_in1_real", in1_real, 0);
        check("midrst_in1_imag", in1_imag, 0);
        check("midrst_in2_real", in2_real, 0);
        check("midrst_in2_imag", in2_imag, 0);
        check("midrst_in_ready", in_ready, 1);
        tick();
        check("midrst_en_hold", en, 0);
        rst_n = 1'b1;
        tick();
        load_frame(20, 1'b0, 8);
        expect_frame(20, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
